// File: rtl/fetch_controller_if.sv
// Instruction memory request/response bus.
// master drives requests, slave grants and returns read data.
interface fetch_controller_if #(
  parameter int addr_size = 16,
  parameter int iw = 8
) ();
  logic                 mem_req;
  logic [addr_size-1:0] mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [iw-1:0]        mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: IP advance/redirect, one outstanding memory read.
// Define FETCH_PREFETCH_EN for a second in-flight read and one-entry buffer.
module fetch_controller #(
  parameter int addr_size = 16,
  parameter int isize = 0,
  localparam int iw = 8 << isize
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic [addr_size-1:0] ip_addr,
  output logic                 ip_incr,
  output logic                 ip_jmp,
  output logic [addr_size-1:0] ip_jaddr,
  input  logic                 redirect,
  input  logic [addr_size-1:0] redirect_addr,
  fetch_controller_if.master   mem,
  output logic                 instr_valid,
  output logic [iw-1:0]        instr,
  output logic [addr_size-1:0] instr_addr,
  input  logic                 instr_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t               state;
  logic                 discard;
  logic [addr_size-1:0] pend_addr;
  logic                 hs;
  logic                 gnt;
  logic                 req_main;
  logic                 pf_req;

  assign hs       = instr_valid & instr_ready;
  assign req_main = (state == REQ) & ~discard;

`ifdef FETCH_PREFETCH_EN
  logic                 pf_out;
  logic                 buf_valid;
  logic [iw-1:0]        buf_data;
  logic [addr_size-1:0] buf_addr;

  assign pf_req = (state == HOLD) & run & ~discard
                & ~pf_out & ~buf_valid;
`else
  assign pf_req = 1'b0;
`endif

  assign mem.mem_req  = req_main | pf_req;
  assign mem.mem_addr = mem.mem_req ? ip_addr : '0;
  assign gnt          = mem.mem_req & mem.mem_gnt;
  assign ip_incr      = gnt & ~redirect;
  assign ip_jmp       = redirect & rstn;
  assign ip_jaddr     = ip_jmp ? redirect_addr : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      discard     <= 1'b0;
      pend_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
`ifdef FETCH_PREFETCH_EN
      pf_out      <= 1'b0;
      buf_valid   <= 1'b0;
      buf_data    <= '0;
      buf_addr    <= '0;
`endif
    end else begin
      // a response owed to a killed request is swallowed here
      if (discard & mem.mem_rvalid) discard <= 1'b0;
      unique case (state)
        IDLE: begin
          if (redirect | run) state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            if (gnt) discard <= 1'b1;
          end else if (gnt) begin
            pend_addr <= mem.mem_addr;
            state     <= WAIT;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (redirect) begin
            if (!mem.mem_rvalid) discard <= 1'b1;
            state <= REQ;
          end else if (mem.mem_rvalid) begin
            instr       <= mem.mem_rdata;
            instr_addr  <= pend_addr;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            state       <= REQ;
`ifdef FETCH_PREFETCH_EN
            buf_valid   <= 1'b0;
            pf_out      <= 1'b0;
            if (gnt | (pf_out & ~mem.mem_rvalid)) discard <= 1'b1;
`endif
          end else begin
`ifdef FETCH_PREFETCH_EN
            if (gnt) begin
              pf_out    <= 1'b1;
              pend_addr <= ip_addr;
            end
            if (pf_out & mem.mem_rvalid) pf_out <= 1'b0;
            if (hs) begin
              if (buf_valid) begin
                instr      <= buf_data;
                instr_addr <= buf_addr;
                buf_valid  <= 1'b0;
              end else if (pf_out & mem.mem_rvalid) begin
                instr      <= mem.mem_rdata;
                instr_addr <= pend_addr;
              end else if (pf_out | gnt) begin
                instr_valid <= 1'b0;
                pf_out      <= 1'b0;
                state       <= WAIT;
              end else begin
                instr_valid <= 1'b0;
                state       <= run ? REQ : IDLE;
              end
            end else if (pf_out & mem.mem_rvalid) begin
              buf_valid <= 1'b1;
              buf_data  <= mem.mem_rdata;
              buf_addr  <= pend_addr;
            end
`else
            if (hs) begin
              instr_valid <= 1'b0;
              state       <= run ? REQ : IDLE;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller with a stream-level reference model.
// Model: delivered instructions follow IP order, restarting at each redirect.
module tb_fetch_controller;
  localparam int AW = 16;
  localparam int IS = 1;
  localparam int IW = 16;
  localparam logic [AW-1:0] STEP = 16'd2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          run = 1'b0;
  logic          redirect = 1'b0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] ip_addr = '0;
  logic [AW-1:0] redirect_addr = '0;
  logic [AW-1:0] ip_jaddr;
  logic [AW-1:0] instr_addr;
  logic          ip_incr;
  logic          ip_jmp;
  logic          instr_valid;
  logic [IW-1:0] instr;

  fetch_controller_if #(.addr_size(AW), .iw(IW)) mif ();

  fetch_controller #(.addr_size(AW), .isize(IS)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .run           (run),
    .ip_addr       (ip_addr),
    .ip_incr       (ip_incr),
    .ip_jmp        (ip_jmp),
    .ip_jaddr      (ip_jaddr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem           (mif),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_addr    (instr_addr),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] memfn(logic [AW-1:0] a);
    return (a == 16'h0100) ? 16'hABCD : ({a[7:0], a[15:8]} ^ 16'h3C96);
  endfunction

  function automatic bit roll(int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  int gnt_pct = 100, rdy_pct = 100, rdr_pct = 0, run_pct = 100;
  int lat_min = 0, lat_max = 0;
  bit rdr_now = 1'b0;
  logic [AW-1:0] rdr_target = '0;
  logic [AW-1:0] ip_next = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] pq[$];
  int lat_cnt = 0;
  int incr_cnt = 0;
  int hs_cnt = 0;
  logic p_req = 0, p_gnt = 0, p_rdr = 0, p_run = 0;
  logic p_valid = 0, p_ready = 0;
  logic [AW-1:0] p_addr = '0;
  logic [IW-1:0] p_instr = '0;

  task automatic tick();
    logic g;
    @(negedge clk);
    ip_addr = ip_next;
    run = roll(run_pct);
    mif.mem_gnt = roll(gnt_pct);
    mif.mem_rvalid = (pq.size() > 0) && (lat_cnt == 0);
    mif.mem_rdata = (pq.size() > 0) ? memfn(pq[0]) : 16'h0;
    instr_ready = roll(rdy_pct);
    redirect = rdr_now || roll(rdr_pct);
    redirect_addr = rdr_now ? rdr_target
                  : 16'($urandom_range(32767, 0) * 2);
    rdr_now = 1'b0;
    #1;
    if (p_req && !p_gnt && !p_rdr && p_run) begin
      chk("req_hold", mif.mem_req, 1);
      chk("addr_hold", mif.mem_addr, p_addr);
    end
    if (p_valid && !p_ready && !p_rdr) begin
      chk("valid_hold", instr_valid, 1);
      chk("instr_hold", instr, p_instr);
    end
    chk("jmp", ip_jmp, redirect);
    if (redirect) chk("jaddr", ip_jaddr, redirect_addr);
    g = mif.mem_req & mif.mem_gnt;
    chk("incr", ip_incr, g && !redirect);
    if (g) begin
      chk("gnt_addr", mif.mem_addr, ip_addr);
      chk("one_outstanding", pq.size() - int'(mif.mem_rvalid), 0);
    end
    if (mif.mem_rvalid) void'(pq.pop_front());
    if (g) begin
      pq.push_back(mif.mem_addr);
      lat_cnt = $urandom_range(lat_max, lat_min);
    end else if (lat_cnt > 0) begin
      lat_cnt--;
    end
    if (ip_incr) incr_cnt++;
    ip_next = ip_jmp ? ip_jaddr : (ip_incr ? ip_addr + STEP : ip_addr);
    if (redirect) begin
      exp_addr = redirect_addr;
    end else if (instr_valid && instr_ready) begin
      chk("instr_addr", instr_addr, exp_addr);
      chk("instr", instr, memfn(exp_addr));
      exp_addr = exp_addr + STEP;
      hs_cnt++;
    end
    p_req = mif.mem_req;
    p_gnt = mif.mem_gnt;
    p_rdr = redirect;
    p_run = run;
    p_valid = instr_valid;
    p_ready = instr_ready;
    p_addr = mif.mem_addr;
    p_instr = instr;
  endtask

  function automatic logic sig(int which);
    case (which)
      0: return instr_valid;
      1: return mif.mem_req;
      default: return ip_incr;
    endcase
  endfunction

  task automatic wait_for(string tag, int which, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (sig(which)) break;
    end
    chk({"reach_", tag}, sig(which), 1);
  endtask

  task automatic do_reset(logic [AW-1:0] start, bit keep_q);
    @(negedge clk);
    rstn = 1'b0;
    run = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    #1;
    chk("rst_req", mif.mem_req, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_incr", ip_incr, 0);
    chk("rst_jmp", ip_jmp, 0);
    chk("rst_jaddr", ip_jaddr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_iaddr", instr_addr, 0);
    repeat (2) @(negedge clk);
    if (!keep_q) begin
      pq.delete();
      lat_cnt = 0;
    end
    ip_next = start;
    ip_addr = start;
    exp_addr = start;
    incr_cnt = 0;
    {p_req, p_gnt, p_rdr, p_run, p_valid, p_ready} = '0;
    rstn = 1'b1;
  endtask

  logic [IW-1:0] saved;

  initial begin
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = '0;

    // basic fetch, immediate grant and response
    do_reset(16'h0100, 0);
    wait_for("v029", 0, 10);
    chk("v029_instr", instr, 16'hABCD);
    chk("v029_iaddr", instr_addr, 16'h0100);
    chk("v029_incr", incr_cnt, 1);

    // grant withheld five cycles
    do_reset(16'h0100, 0);
    gnt_pct = 0;
    wait_for("req030", 1, 5);
    for (int i = 0; i < 5; i++) begin
      chk("s030_req", mif.mem_req, 1);
      chk("s030_addr", mif.mem_addr, 16'h0100);
      chk("s030_noincr", incr_cnt, 0);
      if (i < 4) tick();
    end
    gnt_pct = 100;
    wait_for("incr030", 2, 5);
    chk("s030_gaddr", mif.mem_addr, 16'h0100);
    chk("s030_cnt", incr_cnt, 1);

    // redirect while waiting on a slow response
    do_reset(16'h0100, 0);
    lat_min = 3;
    lat_max = 3;
    wait_for("incr031", 2, 5);
    lat_min = 0;
    lat_max = 0;
    rdr_now = 1'b1;
    rdr_target = 16'h0200;
    tick();
    chk("r031_jmp", ip_jmp, 1);
    chk("r031_jaddr", ip_jaddr, 16'h0200);
    chk("r031_noincr", ip_incr, 0);
    wait_for("req031", 1, 10);
    chk("r031_addr", mif.mem_addr, 16'h0200);
    wait_for("v031", 0, 10);
    chk("r031_iaddr", instr_addr, 16'h0200);
    chk("r031_instr", instr, memfn(16'h0200));

    // address wrap
    do_reset(16'hFFFE, 0);
    wait_for("v032", 0, 10);
    chk("w032_iaddr", instr_addr, 16'hFFFE);
    wait_for("req032", 1, 5);
    chk("w032_addr", mif.mem_addr, 16'h0000);

    // decode back-pressure
    do_reset(16'h0300, 0);
    rdy_pct = 0;
    wait_for("v033", 0, 10);
    saved = instr;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h033_valid", instr_valid, 1);
      chk("h033_instr", instr, saved);
      chk("h033_iaddr", instr_addr, 16'h0300);
    end
    rdy_pct = 100;
    tick();

    // reset while a response is in flight
    lat_min = 3;
    lat_max = 3;
    wait_for("incr034", 2, 10);
    tick();
    do_reset(16'h0400, 1);
    run_pct = 0;
    gnt_pct = 0;
    lat_min = 0;
    lat_max = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("x034_novalid", instr_valid, 0);
    end

    // randomized traffic
    gnt_pct = 60;
    rdy_pct = 60;
    rdr_pct = 3;
    run_pct = 90;
    lat_min = 0;
    lat_max = 3;
    do_reset(16'($urandom_range(32767, 0) * 2), 0);
    hs_cnt = 0;
    for (int i = 0; i < 4000; i++) tick();
    chk("rand_progress", hs_cnt > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
